fifo_wr_frame_gen: RTL

Write-domain frame source that sits directly upstream of the asynchronous FIFO's write port, clocked by wr_clk. On a start pulse it emits one frame: header, a variable-length payload from a running data counter, and an XOR checksum trailer. It presents one word at a time on wr_data/wr_en and stalls without loss while the FIFO reports wr_full. It replaces the free-running ROM stimulus with flow-controlled, self-checking traffic.

---
 rtl/fifo_wr_pkg.sv | 19 +
 rtl/fifo_wr_frame_gen.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fifo_wr_pkg.sv
// Shared definitions for the write-domain frame generator: state encoding,
// header tag and the default payload seed.
package fifo_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_TRL,
    ST_GAP
  } state_t;

  // Upper nibble of every header word; the lower nibble carries len.
  localparam logic [3:0] HDR_TAG = 4'hA;

  // Power-up value of the running payload counter.
  localparam logic [7:0] DEFAULT_SEED = 8'd10;

endpackage

// File: rtl/fifo_wr_frame_gen.sv
// Write-domain frame source feeding the asynchronous FIFO write port.
// Each start request produces one frame: a header word, len+1 payload bytes
// taken from a running counter, and an XOR checksum trailer. Words are
// presented one at a time on wr_data/wr_en and held unchanged while the FIFO
// reports full, so nothing is lost or repeated under back-pressure.
module fifo_wr_frame_gen
  import fifo_wr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               LEN_W = 4,
  parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED,
  parameter int               GAP   = 2
) (
  input  logic             wr_clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             wr_full,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       frames_sent
);

  // The gap counter needs at least one bit even when GAP is 0 or 1.
  localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

  state_t             r_state;
  logic [LEN_W-1:0]   r_lenQ;
  logic [LEN_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_dataCnt;
  logic [WIDTH-1:0]   r_csum;
  logic [GAP_W-1:0]   r_gapCnt;
  logic               r_wrEn;
  logic [WIDTH-1:0]   r_wrData;
  logic               r_busy;
  logic               r_frameDone;
  logic [7:0]         r_framesSent;

  logic               w_accept;
  logic [WIDTH-1:0]   w_hdrWord;
  logic [WIDTH-1:0]   w_cntNext;

  // The FIFO takes the word on any edge where we offer it and it has room;
  // wr_full is used directly against the registered wr_en, no extra stage.
  assign w_accept  = r_wrEn & ~wr_full;
  assign w_hdrWord = WIDTH'({HDR_TAG, len});
  assign w_cntNext = r_dataCnt + WIDTH'(1);

  // Frame sequencer: every output is a register updated here, and all
  // progress is gated on acceptance so a full FIFO freezes the frame.
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_lenQ       <= '0;
      r_idx        <= '0;
      r_dataCnt    <= SEED;
      r_csum       <= '0;
      r_gapCnt     <= '0;
      r_wrEn       <= 1'b0;
      r_wrData     <= '0;
      r_busy       <= 1'b0;
      r_frameDone  <= 1'b0;
      r_framesSent <= '0;
    end else begin
      r_frameDone <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_lenQ   <= len;
            r_csum   <= '0;
            r_wrEn   <= 1'b1;
            r_wrData <= w_hdrWord;
            r_busy   <= 1'b1;
            r_state  <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (w_accept) begin
            r_csum   <= r_csum ^ r_wrData;
            r_idx    <= '0;
            r_wrData <= r_dataCnt;
            r_state  <= ST_PAY;
          end
        end
        ST_PAY: begin
          if (w_accept) begin
            r_csum    <= r_csum ^ r_wrData;
            r_dataCnt <= w_cntNext;
            r_idx     <= r_idx + LEN_W'(1);
            if (r_idx == r_lenQ) begin
              // Trailer is the running XOR folded with the last payload byte.
              r_wrData <= r_csum ^ r_wrData;
              r_state  <= ST_TRL;
            end else begin
              r_wrData <= w_cntNext;
            end
          end
        end
        ST_TRL: begin
          if (w_accept) begin
            r_framesSent <= r_framesSent + 8'd1;
            r_frameDone  <= 1'b1;
            r_wrEn       <= 1'b0;
            r_wrData     <= '0;
            r_gapCnt     <= '0;
            if (GAP == 0) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (r_gapCnt == GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gapCnt <= r_gapCnt + GAP_W'(1);
          end
        end
        default: begin
          r_wrEn  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr_en       = r_wrEn;
  assign wr_data     = r_wrData;
  assign busy        = r_busy;
  assign frame_done  = r_frameDone;
  assign frames_sent = r_framesSent;

endmodule
